// File: rtl/mc_controller_if.sv
// mc_controller_if: bundles the instruction/flag inputs, the datapath
// control outputs and the debug state code of the multicycle controller.
// The master modport is the controller; the slave modport is the datapath.
// There is no valid/ready handshake on this bus. Every output is a Moore
// function of the controller state, and the datapath acts on it in the same
// cycle. Instr is expected to hold stable from the FETCH edge until the
// instruction returns to FETCH.
interface mc_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARMv4-subset core.
// It sequences FETCH/DECODE/MEM*/EXEC*/ALUWB/BRANCH and holds the NZCV flags.
// It also holds the latched condition result (CondReg) that gates every
// architectural write.
// Optional feature: define MC_CMP_EN to decode funct[4:1]=1010 as CMP. CMP
// updates all flags and returns from EXECR/EXECI straight to FETCH.
module mc_controller (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      state;
    logic [3:0]  flags;      // {N,Z,C,V}
    logic        cond_reg;

    // Instruction fields. Instr carries IR[31:12].
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        unused_rn;
    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // Condition check of the current instruction against the flag register.
    logic cond_ex;
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing decode. dp_valid=0 marks an unimplemented command:
    // it still runs through the states, but it writes nothing.
    logic [1:0] dp_alu;
    logic       dp_valid;
    logic       dp_arith;   // ADD/SUB family: C and V are meaningful
    logic       dp_cmp;     // compare only: no register write, no ALUWB
    always_comb begin
        dp_alu   = 2'b00;
        dp_valid = 1'b1;
        dp_arith = 1'b0;
        dp_cmp   = 1'b0;
        case (funct[4:1])
            4'b0100: begin dp_alu = 2'b00; dp_arith = 1'b1; end
            4'b0010: begin dp_alu = 2'b01; dp_arith = 1'b1; end
            4'b0000: dp_alu = 2'b10;
            4'b1100: dp_alu = 2'b11;
`ifdef MC_CMP_EN
            4'b1010: begin dp_alu = 2'b01; dp_arith = 1'b1; dp_cmp = 1'b1; end
`endif
            default: dp_valid = 1'b0;
        endcase
    end

    logic in_exec;
    assign in_exec = (state == EXECR) || (state == EXECI);

    // State sequencing, condition latch and flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            flags    <= 4'b0000;
            cond_reg <= 1'b0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    cond_reg <= cond_ex;
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR, EXECI: state <= dp_cmp ? FETCH : ALUWB;
                default: state <= FETCH;
            endcase
            if (in_exec && cond_reg && dp_valid && (funct[0] || dp_cmp)) begin
                flags[3:2] <= bus.ALUFlags[3:2];
                if (dp_arith) begin
                    flags[1:0] <= bus.ALUFlags[1:0];
                end
            end
        end
    end

    // Moore control outputs decoded from the state, the IR fields and CondReg.
    logic pc_w, ir_w, mem_w, reg_w, adr_src, src_a;
    logic [1:0] src_b, res_src, imm_src, alu_ctl;
    always_comb begin
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        mem_w   = 1'b0;
        reg_w   = 1'b0;
        adr_src = 1'b0;
        src_a   = 1'b0;
        src_b   = 2'b00;
        res_src = 2'b00;
        imm_src = 2'b00;
        alu_ctl = 2'b00;
        case (state)
            FETCH: begin
                ir_w    = 1'b1;
                pc_w    = 1'b1;
                src_a   = 1'b1;
                src_b   = 2'b10;
                res_src = 2'b10;
            end
            DECODE: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                res_src = 2'b10;
            end
            MEMADR: begin
                src_b   = 2'b01;
                imm_src = 2'b01;
            end
            MEMRD: adr_src = 1'b1;
            MEMWB: begin
                res_src = 2'b01;
                // Loads to R15 redirect the PC instead of the register file.
                if (cond_reg) begin
                    if (rd == 4'd15) pc_w = 1'b1;
                    else             reg_w = 1'b1;
                end
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = cond_reg;
            end
            EXECR: alu_ctl = dp_alu;
            EXECI: begin
                src_b   = 2'b01;
                alu_ctl = dp_alu;
            end
            ALUWB: begin
                if (cond_reg && dp_valid) begin
                    if (rd == 4'd15) pc_w = 1'b1;
                    else             reg_w = 1'b1;
                end
            end
            BRANCH: begin
                src_b   = 2'b01;
                imm_src = 2'b10;
                res_src = 2'b10;
                pc_w    = cond_reg;
            end
            default: ;
        endcase
    end

    // FETCH's write enables must not fire while reset is held low.
    assign bus.PCWrite    = pc_w & reset;
    assign bus.IRWrite    = ir_w & reset;
    assign bus.MemWrite   = mem_w;
    assign bus.RegWrite   = reg_w;
    assign bus.AdrSrc     = adr_src;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ResultSrc  = res_src;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_ctl;
    assign bus.State      = state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed bench for mc_controller. Each instruction starts
// at a FETCH; the bench records the outputs on every falling edge and the test
// tasks compare them with hand-derived sequences.
module tb_mc_controller;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle observations of the last instruction run
    logic [3:0] o_state [0:7];
    logic       o_pcw   [0:7];
    logic       o_irw   [0:7];
    logic       o_memw  [0:7];
    logic       o_regw  [0:7];
    logic       o_adr   [0:7];
    logic [1:0] o_srcb  [0:7];
    logic [1:0] o_res   [0:7];
    logic [1:0] o_imm   [0:7];
    logic [1:0] o_aluc  [0:7];
    logic [1:0] o_regsrc[0:7];

    task automatic sample(input int k);
        o_state[k]  = bus.State;
        o_pcw[k]    = bus.PCWrite;
        o_irw[k]    = bus.IRWrite;
        o_memw[k]   = bus.MemWrite;
        o_regw[k]   = bus.RegWrite;
        o_adr[k]    = bus.AdrSrc;
        o_srcb[k]   = bus.ALUSrcB;
        o_res[k]    = bus.ResultSrc;
        o_imm[k]    = bus.ImmSrc;
        o_aluc[k]   = bus.ALUControl;
        o_regsrc[k] = bus.RegSrc;
    endtask

    // Driver: called on a falling edge in FETCH. Records n+1 samples and
    // returns at the falling edge of the following FETCH.
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] fl, input int n);
        bus.Instr    = ins;
        bus.ALUFlags = fl;
        #1;
        sample(0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            #1;
            sample(k);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.Instr    = 20'hEC000;
        bus.ALUFlags = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.State !== 4'd0 || bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: state=%0d irw=%b pcw=%b, expected 0 0 0",
                     bus.State, bus.IRWrite, bus.PCWrite);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.State !== 4'd0 || bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1 ||
            bus.ALUSrcB !== 2'b10 || bus.ALUSrcA !== 1'b1 || bus.ResultSrc !== 2'b10 ||
            bus.AdrSrc !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_fetch: state=%0d irw=%b pcw=%b srcb=%b srca=%b res=%b adr=%b",
                     bus.State, bus.IRWrite, bus.PCWrite, bus.ALUSrcB, bus.ALUSrcA,
                     bus.ResultSrc, bus.AdrSrc);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.State !== 4'd1 || bus.PCWrite !== 1'b0 || bus.IRWrite !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_decode: state=%0d pcw=%b irw=%b, expected 1 0 0",
                     bus.State, bus.PCWrite, bus.IRWrite);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.State !== 4'd0) begin
            tests_failed++;
            $display("FAIL op11_return: state=%0d expected 0", bus.State);
        end
    endtask

    task automatic test_add_imm();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        logic       exp_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        run_instr(20'hE2812, 4'b0000, 4);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (o_state[i] !== exp_s[i] || o_regw[i] !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL add_seq[%0d]: state=%0d regw=%b, expected %0d %b",
                         i, o_state[i], o_regw[i], exp_s[i], exp_w[i]);
            end
        end
        tests_run++;
        if (o_aluc[2] !== 2'b00 || o_srcb[2] !== 2'b01 || o_imm[2] !== 2'b00 ||
            o_res[3] !== 2'b00 || o_irw[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_ctrl: aluc=%b srcb=%b imm=%b res=%b irw=%b, expected 00 01 00 00 1",
                     o_aluc[2], o_srcb[2], o_imm[2], o_res[3], o_irw[0]);
        end
    endtask

    task automatic test_cond_flags();
        logic [19:0] ins  [5] = '{20'h02804, 20'h12804, 20'h22804, 20'h82804, 20'h42804};
        logic        exp_w[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        // SUBS R3,R3,R3 loads N=0 Z=1 C=1 V=0
        run_instr(20'hE0533, 4'b0110, 4);
        tests_run++;
        if (o_state[2] !== 4'd6 || o_aluc[2] !== 2'b01 || o_srcb[2] !== 2'b00 ||
            o_regw[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL subs: state=%0d aluc=%b srcb=%b regw=%b, expected 6 01 00 1",
                     o_state[2], o_aluc[2], o_srcb[2], o_regw[3]);
        end
        // EQ, NE, CS, HI, MI; ALU flags without S must not reach the register
        for (int i = 0; i < 5; i++) begin
            run_instr(ins[i], 4'b1001, 4);
            tests_run++;
            if (o_state[3] !== 4'd8 || o_regw[3] !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL cond[%0d]: state=%0d regw=%b, expected 8 %b",
                         i, o_state[3], o_regw[3], exp_w[i]);
            end
        end
    endtask

    task automatic test_ldr_str();
        logic [3:0] exp_l [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        run_instr(20'hE5905, 4'b0000, 5);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (o_state[i] !== exp_l[i]) begin
                tests_failed++;
                $display("FAIL ldr_state[%0d]: got %0d expected %0d", i, o_state[i], exp_l[i]);
            end
        end
        tests_run++;
        if (o_srcb[2] !== 2'b01 || o_imm[2] !== 2'b01 || o_adr[3] !== 1'b1 ||
            o_res[4] !== 2'b01 || o_regw[4] !== 1'b1 || o_pcw[4] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ldr_ctrl: srcb=%b imm=%b adr=%b res=%b regw=%b pcw=%b",
                     o_srcb[2], o_imm[2], o_adr[3], o_res[4], o_regw[4], o_pcw[4]);
        end
        run_instr(20'hE5805, 4'b0000, 4);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (o_state[i] !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL str_state[%0d]: got %0d expected %0d", i, o_state[i], exp_s[i]);
            end
        end
        tests_run++;
        if (o_memw[3] !== 1'b1 || o_adr[3] !== 1'b1 || o_regsrc[3] !== 2'b10 ||
            o_regw[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL str_ctrl: memw=%b adr=%b regsrc=%b regw=%b, expected 1 1 10 0",
                     o_memw[3], o_adr[3], o_regsrc[3], o_regw[3]);
        end
    endtask

    task automatic test_branch();
        logic [19:0] ins  [2] = '{20'hFA000, 20'hEA000};
        logic        exp_p[2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            run_instr(ins[i], 4'b0000, 3);
            tests_run++;
            if (o_state[2] !== 4'd9 || o_state[3] !== 4'd0 || o_pcw[2] !== exp_p[i]) begin
                tests_failed++;
                $display("FAIL branch[%0d]: states=%0d,%0d pcw=%b, expected 9,0 %b",
                         i, o_state[2], o_state[3], o_pcw[2], exp_p[i]);
            end
            tests_run++;
            if (o_imm[2] !== 2'b10 || o_srcb[2] !== 2'b01 || o_res[2] !== 2'b10 ||
                o_regsrc[2] !== 2'b01) begin
                tests_failed++;
                $display("FAIL branch_ctrl[%0d]: imm=%b srcb=%b res=%b regsrc=%b",
                         i, o_imm[2], o_srcb[2], o_res[2], o_regsrc[2]);
            end
        end
    endtask

    task automatic test_pc_writeback();
        run_instr(20'hE281F, 4'b0000, 4);
        tests_run++;
        if (o_regw[3] !== 1'b0 || o_pcw[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_pc: regw=%b pcw=%b, expected 0 1", o_regw[3], o_pcw[3]);
        end
        run_instr(20'hE590F, 4'b0000, 5);
        tests_run++;
        if (o_state[4] !== 4'd4 || o_regw[4] !== 1'b0 || o_pcw[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ldr_pc: state=%0d regw=%b pcw=%b, expected 4 0 1",
                     o_state[4], o_regw[4], o_pcw[4]);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] ins  [3] = '{20'h02804, 20'h12804, 20'h22804};
        logic        exp_w[3] = '{1'b0, 1'b1, 1'b0};
        run_instr(20'hE5805, 4'b0000, 3);
        tests_run++;
        if (o_state[3] !== 4'd5 || o_memw[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_memwr: state=%0d memw=%b, expected 5 1", o_state[3], o_memw[3]);
        end
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.MemWrite !== 1'b0 || bus.State !== 4'd0 || bus.PCWrite !== 1'b0 ||
            bus.IRWrite !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: memw=%b state=%0d pcw=%b irw=%b, expected 0 0 0 0",
                     bus.MemWrite, bus.State, bus.PCWrite, bus.IRWrite);
        end
        @(negedge clk);
        bus.Instr = 20'hEC000;
        reset     = 1'b1;
        #1;
        tests_run++;
        if (bus.State !== 4'd0 || bus.IRWrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: state=%0d irw=%b, expected 0 1", bus.State, bus.IRWrite);
        end
        @(negedge clk);
        @(negedge clk);
        // Flags were 0110 before the pulse and must now read 0000
        for (int i = 0; i < 3; i++) begin
            run_instr(ins[i], 4'b0000, 4);
            tests_run++;
            if (o_regw[3] !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL flags_cleared[%0d]: regw=%b expected %b", i, o_regw[3], exp_w[i]);
            end
        end
    endtask

    task automatic test_cmp();
`ifdef MC_CMP_EN
        logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd7, 4'd0};
        logic [1:0] exp_aluc  = 2'b01;
        logic       exp_eq_w  = 1'b1;
        int         n         = 3;
`else
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        logic [1:0] exp_aluc  = 2'b00;
        logic       exp_eq_w  = 1'b0;
        int         n         = 4;
`endif
        // Flags are 0000 here; the ALU reports Z=1 C=1
        run_instr(20'hE3510, 4'b0110, n);
        for (int i = 0; i <= n; i++) begin
            tests_run++;
            if (o_state[i] !== exp_s[i] || o_regw[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL cmp_seq[%0d]: state=%0d regw=%b, expected %0d 0",
                         i, o_state[i], o_regw[i], exp_s[i]);
            end
        end
        tests_run++;
        if (o_aluc[2] !== exp_aluc) begin
            tests_failed++;
            $display("FAIL cmp_aluc: got %b expected %b", o_aluc[2], exp_aluc);
        end
        run_instr(20'h02804, 4'b0000, 4);
        tests_run++;
        if (o_regw[3] !== exp_eq_w) begin
            tests_failed++;
            $display("FAIL cmp_flags: addeq regw=%b expected %b", o_regw[3], exp_eq_w);
        end
    endtask

    // Test sequence and final report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add_imm();
        test_cond_flags();
        test_ldr_str();
        test_branch();
        test_pc_writeback();
        test_reset_mid();
        test_cmp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
